dram_cache_rob: RTL and testbench

Reorder buffer between the tag-compare stage and the AXI R channel toward the CPU.
- Allocates a transaction ID (TID) per accepted read in request order.
- Takes completed read data in any order from two sources: read-hit writes from tag compare, and miss-return writes from the backing-memory refill path.
- Returns data on the R channel strictly in allocation order, restoring the original AXI ID.

---
 rtl/dram_cache_rob.sv | 154 +++++++++++++++
 tb/tb_dram_cache_rob.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cache_rob.sv
// Reorder buffer between tag compare and the AXI R channel: TIDs are allocated in
// request order, completions arrive in any order, R beats leave in allocation order.

module dram_cache_rob_entry #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_en,
  input  logic [ID_WIDTH-1:0]   alloc_id,
  input  logic                  hit_en,
  input  logic [DATA_WIDTH-1:0] hit_data,
  input  logic                  miss_en,
  input  logic [DATA_WIDTH-1:0] miss_data,
  input  logic                  drain_en,
  output logic [ID_WIDTH-1:0]   id,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  done,
  output logic                  done_nxt
);
  // Alloc/write and write/drain are mutually exclusive by construction in the parent.
  always_comb begin
    done_nxt = done;
    if (alloc_en | drain_en) done_nxt = 1'b0;
    if (hit_en | miss_en)    done_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= done_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (alloc_en) id <= alloc_id;
      if (hit_en)       data <= hit_data;
      else if (miss_en) data <= miss_data;
    end
  end
endmodule

module dram_cache_rob #(
  parameter int DATA_WIDTH   = 128,
  parameter int ID_WIDTH     = 4,
  parameter int TID_WIDTH    = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_req_i,
  input  logic [ID_WIDTH-1:0]           alloc_id_i,
  output logic                          alloc_gnt_o,
  output logic [TID_WIDTH-1:0]          alloc_tid_o,
  input  logic                          hit_wren_i,
  input  logic [TID_WIDTH+DATA_WIDTH-1:0] hit_data_i,
  input  logic                          miss_wren_i,
  input  logic [TID_WIDTH+DATA_WIDTH-1:0] miss_data_i,
  output logic                          rob_afull_o,
  output logic [ID_WIDTH-1:0]           rid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [1:0]                    rresp_o,
  output logic                          rlast_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic                          err_o,
  output logic [TID_WIDTH:0]            count_o
);
  localparam int DEPTH = 1 << TID_WIDTH;
  localparam int PW    = TID_WIDTH + 1;

  logic [PW-1:0]        head, tail, count, done_cnt;
  logic [TID_WIDTH-1:0] head_idx, tail_idx, hit_tid, miss_tid, hit_off, miss_off;
  logic                 full, hit_legal, miss_legal, miss_clash, wr_err, load;

  logic [DEPTH-1:0]                 ent_done, ent_done_nxt;
  logic [DEPTH-1:0][ID_WIDTH-1:0]   ent_id;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;

  assign count    = tail - head;
  assign full     = (count == PW'(DEPTH));
  assign head_idx = head[TID_WIDTH-1:0];
  assign tail_idx = tail[TID_WIDTH-1:0];

  assign alloc_gnt_o = alloc_req_i & ~full & ~rst;
  assign alloc_tid_o = tail_idx;

  assign hit_tid  = hit_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
  assign miss_tid = miss_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
  assign hit_off  = hit_tid - head_idx;
  assign miss_off = miss_tid - head_idx;

  // An entry is live when its distance from head is below the occupancy.
  assign hit_legal  = hit_wren_i & ({1'b0, hit_off} < count) & ~ent_done[hit_tid];
  assign miss_clash = hit_wren_i & (hit_tid == miss_tid);
  assign miss_legal = miss_wren_i & ({1'b0, miss_off} < count) & ~ent_done[miss_tid] & ~miss_clash;
  assign wr_err     = (hit_wren_i & ~hit_legal) | (miss_wren_i & ~miss_legal);

  assign load = ent_done[head_idx] & (~rvalid_o | rready_i);

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      dram_cache_rob_entry #(.DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) u_ent (
        .clk      (clk),
        .rst      (rst),
        .alloc_en (alloc_gnt_o & (tail_idx == TID_WIDTH'(i))),
        .alloc_id (alloc_id_i),
        .hit_en   (hit_legal & (hit_tid == TID_WIDTH'(i))),
        .hit_data (hit_data_i[DATA_WIDTH-1:0]),
        .miss_en  (miss_legal & (miss_tid == TID_WIDTH'(i))),
        .miss_data(miss_data_i[DATA_WIDTH-1:0]),
        .drain_en (load & (head_idx == TID_WIDTH'(i))),
        .id       (ent_id[i]),
        .data     (ent_data[i]),
        .done     (ent_done[i]),
        .done_nxt (ent_done_nxt[i])
      );
    end
  endgenerate

  always_comb begin
    done_cnt = '0;
    for (int k = 0; k < DEPTH; k++) done_cnt += PW'(ent_done_nxt[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      rvalid_o    <= 1'b0;
      rid_o       <= '0;
      rdata_o     <= '0;
      rob_afull_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (alloc_gnt_o) tail <= tail + 1'b1;
      if (load) begin
        head     <= head + 1'b1;
        rvalid_o <= 1'b1;
        rid_o    <= ent_id[head_idx];
        rdata_o  <= ent_data[head_idx];
      end else if (rready_i) begin
        rvalid_o <= 1'b0;
      end
      rob_afull_o <= (done_cnt >= PW'(DEPTH - AFULL_MARGIN));
      if (wr_err) err_o <= 1'b1;
    end
  end

  assign rresp_o = 2'b00;
  assign rlast_o = rvalid_o;
  assign count_o = count;
endmodule

// File: tb/tb_dram_cache_rob.sv
// Directed plus randomized bench for dram_cache_rob, scored against a queue-based
// model of allocation order, completion and the R output slot.

module tb_dram_cache_rob;
  localparam int DW = 128, IW = 4, TW = 4, DEPTH = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic alloc_req = 1'b0, hit_wren = 1'b0, miss_wren = 1'b0, rready = 1'b1;
  logic [IW-1:0] alloc_id = '0;
  logic [TW-1:0] hit_tid = '0, miss_tid = '0;
  logic [DW-1:0] hit_d = '0, miss_d = '0;
  logic alloc_gnt, rob_afull, rlast, rvalid, err;
  logic [TW-1:0] alloc_tid;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [TW:0]   count;

  always #5 clk = ~clk;

  dram_cache_rob #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .TID_WIDTH(TW), .AFULL_MARGIN(2)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req), .alloc_id_i(alloc_id), .alloc_gnt_o(alloc_gnt), .alloc_tid_o(alloc_tid),
    .hit_wren_i(hit_wren), .hit_data_i({hit_tid, hit_d}),
    .miss_wren_i(miss_wren), .miss_data_i({miss_tid, miss_d}),
    .rob_afull_o(rob_afull), .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
    .rvalid_o(rvalid), .rready_i(rready), .err_o(err), .count_o(count)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [TW-1:0] tid;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    bit            done;
  } ent_t;

  ent_t q[$];
  bit m_ov = 0, m_err = 0, m_afull = 0;
  logic [IW-1:0] m_rid = '0;
  logic [DW-1:0] m_rdata = '0;
  int m_alloc_n = 0;

  function automatic int find(input logic [TW-1:0] t);
    foreach (q[k]) if (q[k].tid == t) return k;
    return -1;
  endfunction

  // One clock: compare DUT against the model at negedge, advance the model, step past posedge.
  task automatic cycle();
    bit gnt, load, hl, ml;
    int hi, mi, nd;
    ent_t e;
    @(negedge clk);
    gnt = alloc_req && (q.size() < DEPTH) && !rst;
    chk("alloc_gnt", DW'(alloc_gnt), DW'(gnt));
    if (gnt) chk("alloc_tid", DW'(alloc_tid), DW'(m_alloc_n % DEPTH));
    chk("rvalid", DW'(rvalid), DW'(m_ov));
    chk("rlast", DW'(rlast), DW'(m_ov));
    chk("rresp", DW'(rresp), DW'(0));
    chk("rid", DW'(rid), DW'(m_rid));
    chk("rdata", rdata, m_rdata);
    chk("count", DW'(count), DW'(q.size()));
    chk("afull", DW'(rob_afull), DW'(m_afull));
    chk("err", DW'(err), DW'(m_err));
    if (rst) begin
      q.delete(); m_ov = 0; m_rid = '0; m_rdata = '0; m_err = 0; m_afull = 0; m_alloc_n = 0;
    end else begin
      hi = hit_wren ? find(hit_tid) : -1;
      mi = miss_wren ? find(miss_tid) : -1;
      hl = 0; ml = 0;
      if (hi >= 0) hl = !q[hi].done;
      if (mi >= 0) ml = !q[mi].done && !(hit_wren && hit_tid == miss_tid);
      if ((hit_wren && !hl) || (miss_wren && !ml)) m_err = 1;
      load = 0;
      if (q.size() > 0) load = q[0].done && (!m_ov || rready);
      if (hl) begin q[hi].data = hit_d;  q[hi].done = 1; end
      if (ml) begin q[mi].data = miss_d; q[mi].done = 1; end
      if (load) begin
        m_ov = 1; m_rid = q[0].id; m_rdata = q[0].data;
        void'(q.pop_front());
      end else if (rready) m_ov = 0;
      if (gnt) begin
        e.tid = TW'(m_alloc_n % DEPTH); e.id = alloc_id; e.data = '0; e.done = 0;
        q.push_back(e);
        m_alloc_n++;
      end
      nd = 0;
      foreach (q[k]) nd += int'(q[k].done);
      m_afull = (nd >= DEPTH - 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alloc_req = 0; hit_wren = 0; miss_wren = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  task automatic alloc(input logic [IW-1:0] id);
    alloc_req = 1; alloc_id = id; cycle(); alloc_req = 0;
  endtask

  task automatic hit(input logic [TW-1:0] t, input logic [DW-1:0] d);
    hit_wren = 1; hit_tid = t; hit_d = d; cycle(); hit_wren = 0;
  endtask

  task automatic miss(input logic [TW-1:0] t, input logic [DW-1:0] d);
    miss_wren = 1; miss_tid = t; miss_d = d; cycle(); miss_wren = 0;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    rready = 1; idle();
    while ((count != 0 || rvalid) && n < 60) begin cycle(); n++; end
    chk(tag, DW'({count, rvalid}), DW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] aa, d0, hd, md;
    logic [TW-1:0] pend[$];
    int ri;

    // basic path
    rready = 1;
    do_reset(); do_reset();
    chk("rst_count", DW'(count), DW'(0));
    chk("rst_rvalid", DW'(rvalid), DW'(0));
    aa = {16{8'hAA}};
    alloc(3);
    hit(0, aa);
    chk("s1_rv_early", DW'(rvalid), DW'(0));
    run(1);
    chk("s1_rvalid", DW'(rvalid), DW'(1));
    chk("s1_rid", DW'(rid), DW'(3));
    chk("s1_rdata", rdata, aa);
    chk("s1_rlast", DW'(rlast), DW'(1));
    run(1);
    chk("s1_count", DW'(count), DW'(0));

    // out-of-order completion
    do_reset();
    for (int k = 0; k < 4; k++) alloc(IW'(5 + k));
    hit(3, rnd128()); hit(1, rnd128()); hit(2, rnd128());
    run(2);
    chk("ooo_no_rv", DW'(rvalid), DW'(0));
    hit(0, rnd128());
    for (int k = 0; k < 4; k++) begin
      run(1);
      chk("ooo_rv", DW'(rvalid), DW'(1));
      chk("ooo_rid", DW'(rid), DW'(5 + k));
    end
    run(1);
    chk("ooo_end", DW'(rvalid), DW'(0));

    // full, afull, backpressure, wrap
    do_reset();
    rready = 0;
    for (int k = 0; k < DEPTH; k++) alloc(IW'(k));
    alloc_req = 1; #1;
    chk("full_gnt", DW'(alloc_gnt), DW'(0));
    chk("full_count", DW'(count), DW'(16));
    cycle(); alloc_req = 0;
    for (int t = 1; t <= 14; t++) begin
      hit(TW'(t), rnd128());
      if (t == 13) chk("afull_13", DW'(rob_afull), DW'(0));
    end
    chk("afull_14", DW'(rob_afull), DW'(1));
    d0 = rnd128();
    hit(0, d0); hit(15, rnd128());
    for (int k = 0; k < 3; k++) begin
      run(1);
      chk("stall_rv", DW'(rvalid), DW'(1));
      chk("stall_data", rdata, d0);
    end
    drain("full_drain");
    for (int k = 0; k < 20; k++) begin
      alloc_req = 1; alloc_id = IW'(k);
      hit_wren = (k > 0); hit_tid = TW'((k + 15) % DEPTH); hit_d = rnd128();
      #1;
      chk("wrap_gnt", DW'(alloc_gnt), DW'(1));
      chk("wrap_tid", DW'(alloc_tid), DW'(k % DEPTH));
      cycle();
    end
    idle();
    hit(3, rnd128());
    drain("wrap_drain");

    // simultaneous writes to the same TID
    do_reset();
    for (int k = 0; k < 3; k++) alloc(IW'(k + 1));
    hd = rnd128(); md = rnd128();
    hit_wren = 1; hit_tid = 2; hit_d = hd; miss_wren = 1; miss_tid = 2; miss_d = md;
    cycle(); idle();
    chk("clash_err", DW'(err), DW'(1));
    hit(0, rnd128()); hit(1, rnd128());
    run(2);
    chk("clash_rid", DW'(rid), DW'(3));
    chk("clash_data", rdata, hd);
    drain("clash_drain");

    // simultaneous writes to different TIDs
    do_reset();
    for (int k = 0; k < 5; k++) alloc(IW'(k));
    hit_wren = 1; hit_tid = 1; hit_d = rnd128(); miss_wren = 1; miss_tid = 4; miss_d = rnd128();
    cycle(); idle();
    hit(0, rnd128()); miss(2, rnd128()); hit(3, rnd128());
    drain("dual_drain");
    chk("dual_err", DW'(err), DW'(0));

    // illegal write
    do_reset();
    alloc(1); alloc(2);
    hit(9, rnd128());
    chk("illegal_err", DW'(err), DW'(1));
    run(3);
    chk("illegal_rv", DW'(rvalid), DW'(0));
    chk("illegal_count", DW'(count), DW'(2));

    // reset mid-operation
    do_reset();
    rready = 0;
    for (int k = 0; k < 6; k++) alloc(IW'(k));
    hit(0, rnd128());
    run(1);
    chk("mid_rv", DW'(rvalid), DW'(1));
    rst = 1; cycle(); rst = 0;
    chk("mid_rst_rv", DW'(rvalid), DW'(0));
    chk("mid_rst_count", DW'(count), DW'(0));
    chk("mid_rst_err", DW'(err), DW'(0));
    alloc_req = 1; alloc_id = 7; #1;
    chk("mid_rst_tid", DW'(alloc_tid), DW'(0));
    chk("mid_rst_gnt", DW'(alloc_gnt), DW'(1));
    cycle(); idle();

    // randomized traffic
    do_reset();
    repeat (3000) begin
      pend.delete();
      foreach (q[k]) if (!q[k].done) pend.push_back(q[k].tid);
      rst       = ($urandom_range(0, 399) == 0);
      alloc_req = ($urandom_range(0, 2) != 0);
      alloc_id  = IW'($urandom);
      rready    = ($urandom_range(0, 3) != 0);
      hit_wren  = 0; miss_wren = 0;
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        ri = $urandom_range(0, pend.size() - 1);
        hit_wren = 1; hit_tid = pend[ri]; hit_d = rnd128();
      end
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        ri = $urandom_range(0, pend.size() - 1);
        miss_wren = 1; miss_tid = pend[ri]; miss_d = rnd128();
      end
      if ($urandom_range(0, 63) == 0) begin hit_wren = 1; hit_tid = TW'($urandom); hit_d = rnd128(); end
      cycle();
    end
    rst = 0;
    idle();
    for (int k = 0; k < DEPTH; k++) if (find(TW'(k)) >= 0) hit(TW'(k), rnd128());
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
